// File: rtl/decode.sv
// RV32I decode stage: field/immediate extraction, 32x32 register file with write-back bypass, load-use stall.
// Latency: one cycle from IF_ID to the registered ID_EX outputs.
// Backpressure: combinational stall holds fetch for one cycle on a load-use pair; flush from execute overrides it.
module decode #(
  parameter int unsigned DATA_W  = 32,
  parameter logic [6:0]  LOAD_OP = 7'b0000011
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [63:0]       IF_ID,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              id_valid,
  output logic [31:0]       id_pc,
  output logic [DATA_W-1:0] id_rs1_data,
  output logic [DATA_W-1:0] id_rs2_data,
  output logic [31:0]       id_imm,
  output logic [4:0]        id_rs1,
  output logic [4:0]        id_rs2,
  output logic [4:0]        id_rd,
  output logic [6:0]        id_opcode,
  output logic [2:0]        id_funct3,
  output logic [6:0]        id_funct7,
  output logic              id_mem_read
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic [DATA_W-1:0] rf_q [32];

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [31:0]       imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [6:0]        opcode_q, opcode_d, funct7_q, funct7_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              mem_read_q, mem_read_d;

  assign inst   = IF_ID[31:0];
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  always_comb begin
    imm = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {inst[31:12], 12'b0};
      OP_JAL:                   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

  // Write-back in the same cycle wins over the stored value so no extra hazard stall is needed.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != 5'd0) rs1_data = (wb_en && wb_addr == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0) rs2_data = (wb_en && wb_addr == rs2) ? wb_data : rf_q[rs2];
  end

  assign stall = reset & if_valid & valid_q & mem_read_q & (rd_q != 5'd0) &
                 ((rd_q == rs1) | (rd_q == rs2)) & ~flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    valid_d    = 1'b0;
    pc_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    opcode_d   = '0;
    funct3_d   = '0;
    funct7_d   = '0;
    mem_read_d = 1'b0;
    if (!flush && !stall && if_valid) begin
      valid_d    = 1'b1;
      pc_d       = IF_ID[63:32];
      rs1_data_d = rs1_data;
      rs2_data_d = rs2_data;
      imm_d      = imm;
      rs1_d      = rs1;
      rs2_d      = rs2;
      rd_d       = rd;
      opcode_d   = opcode;
      funct3_d   = funct3;
      funct7_d   = funct7;
      mem_read_d = (opcode == LOAD_OP);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      mem_read_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      funct7_q   <= funct7_d;
      mem_read_q <= mem_read_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_pc       = pc_q;
  assign id_rs1_data = rs1_data_q;
  assign id_rs2_data = rs2_data_q;
  assign id_imm      = imm_q;
  assign id_rs1      = rs1_q;
  assign id_rs2      = rs2_q;
  assign id_rd       = rd_q;
  assign id_opcode   = opcode_q;
  assign id_funct3   = funct3_q;
  assign id_funct7   = funct7_q;
  assign id_mem_read = mem_read_q;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: vector table plus hand-written load-use, flush and reset sequences.
// Expected ID_EX records are queued when stimulus is driven and popped one cycle later.
module tb_decode;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        memrd;
  } out_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    out_t        e;
  } vec_t;

  logic        clock, reset;
  logic [63:0] IF_ID;
  logic        if_valid, flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall, id_valid, id_mem_read;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;

  int n_checks = 0;
  int n_fail   = 0;
  out_t sb[$];
  out_t act;
  vec_t tbl [8];

  decode #(.DATA_W(32), .LOAD_OP(7'b0000011)) dut (
    .clock(clock), .reset(reset), .IF_ID(IF_ID), .if_valid(if_valid), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_mem_read(id_mem_read)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign act = {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
                id_opcode, id_funct3, id_funct7, id_mem_read};

  function automatic out_t mk(input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
                              input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [6:0] opc, input logic [2:0] f3,
                              input logic [6:0] f7, input logic memrd);
    return {1'b1, pc, rs1d, rs2d, imm, rs1, rs2, rd, opc, f3, f7, memrd};
  endfunction

  task automatic check_rec(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Drive one decode cycle at the falling edge and queue the ID_EX record due after the next rising edge.
  task automatic step(input logic [31:0] pc, input logic [31:0] inst, input logic v, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input out_t e, input logic exp_stall, input string name);
    @(negedge clock);
    IF_ID    = {pc, inst};
    if_valid = v;
    flush    = fl;
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    sb.push_back(e);
    #1;
    check_bit({name, "_stall"}, stall, exp_stall);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) check_rec("idex", act, sb.pop_front());
    end
  end

  initial begin
    reset    = 1'b0;
    IF_ID    = {$urandom, $urandom};
    if_valid = 1'b1;
    flush    = 1'b0;
    wb_en    = 1'b0;
    wb_addr  = 5'd0;
    wb_data  = 32'd0;

    tbl[0] = '{32'h10, 32'hFFF00093, 1'b0, 5'd0, 32'h0,
               mk(32'h10, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 7'h13, 3'd0, 7'h7F, 1'b0)};
    tbl[1] = '{32'h14, 32'h00318233, 1'b1, 5'd3, 32'hDEADBEEF,
               mk(32'h14, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 5'd3, 5'd3, 5'd4, 7'h33, 3'd0, 7'h00, 1'b0)};
    tbl[2] = '{32'h18, 32'h000002B3, 1'b1, 5'd0, 32'h55555555,
               mk(32'h18, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 7'h33, 3'd0, 7'h00, 1'b0)};
    tbl[3] = '{32'h1C, 32'h00300333, 1'b1, 5'd5, 32'hCAFEF00D,
               mk(32'h1C, 32'h0, 32'hDEADBEEF, 32'h0, 5'd0, 5'd3, 5'd6, 7'h33, 3'd0, 7'h00, 1'b0)};
    tbl[4] = '{32'h20, 32'hFE000EE3, 1'b0, 5'd0, 32'h0,
               mk(32'h20, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd29, 7'h63, 3'd0, 7'h7F, 1'b0)};
    tbl[5] = '{32'h24, 32'h008000EF, 1'b0, 5'd0, 32'h0,
               mk(32'h24, 32'h0, 32'h0, 32'h00000008, 5'd0, 5'd8, 5'd1, 7'h6F, 3'd0, 7'h00, 1'b0)};
    tbl[6] = '{32'h28, 32'hFE112E23, 1'b0, 5'd0, 32'h0,
               mk(32'h28, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd2, 5'd1, 5'd28, 7'h23, 3'd2, 7'h7F, 1'b0)};
    tbl[7] = '{32'h2C, 32'h123453B7, 1'b0, 5'd0, 32'h0,
               mk(32'h2C, 32'h0, 32'hDEADBEEF, 32'h12345000, 5'd8, 5'd3, 5'd7, 7'h37, 3'd5, 7'h09, 1'b0)};

    repeat (3) @(negedge clock);
    check_rec("reset_idex", act, '0);
    check_bit("reset_stall", stall, 1'b0);
    reset    = 1'b1;
    if_valid = 1'b0;

    for (int i = 0; i < 8; i++)
      step(tbl[i].pc, tbl[i].inst, 1'b1, 1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].e, 1'b0, "vec");

    // Load-use: one bubble, then the dependent add decodes without a second stall.
    step(32'h40, 32'h0000A103, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
         mk(32'h40, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 7'h03, 3'd2, 7'h00, 1'b1), 1'b0, "lu_lw");
    step(32'h44, 32'h002101B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, '0, 1'b1, "lu_stall");
    step(32'h44, 32'h002101B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
         mk(32'h44, 32'h0, 32'h0, 32'h0, 5'd2, 5'd2, 5'd3, 7'h33, 3'd0, 7'h00, 1'b0), 1'b0, "lu_add");

    // Flush overrides the stall and bubbles the slot.
    step(32'h50, 32'h0000A103, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
         mk(32'h50, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 7'h03, 3'd2, 7'h00, 1'b1), 1'b0, "fl_lw");
    step(32'h54, 32'h002101B3, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, '0, 1'b0, "fl_flush");
    step(32'h58, 32'h002101B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
         mk(32'h58, 32'h0, 32'h0, 32'h0, 5'd2, 5'd2, 5'd3, 7'h33, 3'd0, 7'h00, 1'b0), 1'b0, "fl_add");

    // Reset in the middle of a stall: stall and ID_EX drop at once, registers are cleared.
    step(32'h60, 32'h0000A103, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
         mk(32'h60, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 7'h03, 3'd2, 7'h00, 1'b1), 1'b0, "rs_lw");
    step(32'h64, 32'h002101B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, '0, 1'b1, "rs_stall");
    reset = 1'b0;
    #1;
    check_bit("rs_async_stall", stall, 1'b0);
    check_bit("rs_async_valid", id_valid, 1'b0);
    @(negedge clock);
    reset    = 1'b1;
    if_valid = 1'b0;
    step(32'h70, 32'h00528333, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
         mk(32'h70, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd6, 7'h33, 3'd0, 7'h00, 1'b0), 1'b0, "rs_x5");

    // An invalid slot behind a load neither stalls nor decodes.
    step(32'h80, 32'h0000A103, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
         mk(32'h80, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 7'h03, 3'd2, 7'h00, 1'b1), 1'b0, "iv_lw");
    step(32'h84, 32'h002101B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, '0, 1'b0, "iv_bubble");

    @(negedge clock);
    if_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d records outstanding, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
